seg7_scan_decoder: RTL and testbench
====================================

# seg7_scan_decoder

Receive-side counterpart of the watch's BCD-to-7-segment encoder: samples a time-multiplexed, active-low 7-segment display bus (segment pattern plus one-hot digit select) and recovers the BCD value of each digit. Each pattern must hold stable for a programmable number of cycles before it is accepted. Recovered digits are stored per position, illegal patterns are flagged, and a pulse marks each complete frame. It sits between a scanned display bus (self-test loopback or external display tap) and the watch's time-compare and check logic.

## Interface
- DIGITS, 6, number of multiplexed digit positions (HH:MM:SS); range 1..8
- STABLE, 4, consecutive identical samples required before commit; range 2..15
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- seg_in  in  [0:6]  segment pattern, active-low, seg_in[0]=a … seg_in[6]=g
- dig_sel  in  DIGITS  one-hot active-high position select; bit i = digit i, bit 0 = least significant (seconds units)
- bcd_out  out  4*DIGITS  recovered digits; bcd_out[4i+3:4i] = digit i
- digit_valid  out  DIGITS  bit i set once digit i holds a legally decoded value
- frame_valid  out  1  one-cycle pulse: every digit legally committed since last pulse
- err  out  1  one-cycle pulse: illegal pattern committed
- err_digit  out  3  index of the digit that caused the most recent err

## Operation
- Legal patterns (seg_in[0:6] -> value): 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4, 0100100->5, 0100000->6, 0001101->7, 0000000->8, 0000100->9, 1111111 (blank)->4'hF. Any other pattern is illegal.
- Sample stage: {dig_sel, seg_in} registered every cycle into s_reg; the previous s_reg is kept for comparison.
- Stability counter cnt (4 bits): new sample != previous -> cnt<=1; equal -> cnt<=cnt+1, saturating at STABLE.
- Commit fires once per stable run, on the edge where cnt goes STABLE-1 -> STABLE. After that, no further commit until the sample changes.
- Commit with dig_sel not one-hot (zero or multi-hot): ignored. No write, no err. This covers inter-digit blanking and glitches.
- Legal commit, position i: bcd_out slice i <= decoded value; digit_valid[i] <= 1; seen[i] <= 1.
- Illegal commit, position i: err pulses; err_digit <= i; digit_valid[i] <= 0; bcd_out slice i unchanged; seen <= 0 (frame corrupted).
- Frame: when a legal commit makes seen all-ones, frame_valid pulses on that same edge and seen clears to 0. A repeated legal commit of an already-seen digit changes only bcd_out/digit_valid.
- bcd_out, digit_valid and err_digit persist until overwritten.

## Timing
- Reset values: bcd_out=0, digit_valid=0, frame_valid=0, err=0, err_digit=0, seen=0, cnt=0, s_reg={0,7'b1111111}.
- Latency: input applied before edge E0 and held; s_reg loads at E0 (cnt=1); outputs update at edge E0+STABLE-1, i.e. on the STABLE-th consecutive identical sample.
- A pattern held for only STABLE-1 samples is never committed.
- frame_valid and err are registered, high for exactly one cycle, and mutually exclusive (one commit per edge).
- rst mid-run: state and outputs return to reset values on that edge. After release, a full fresh run of STABLE samples is required, even if the inputs never changed.
- No handshake or back-pressure; the bus is observe-only.

## Test plan
- Reset then hold dig_sel=000001, seg_in=0100100 for 4 cycles -> bcd_out[3:0]=5, digit_valid=000001 on the 4th sample edge. Holding for only 3 cycles -> no change.
- Scan digits 0..5 with 1,2,3,4,5,6 (patterns per table, 6 cycles each, one cycle of dig_sel=0 between) -> bcd_out=0x654321, digit_valid=111111, frame_valid one pulse after digit 5 commit.
- Digit 2 with seg_in=1111110 held 4 cycles -> err one pulse, err_digit=2, digit_valid[2]=0, bcd_out[11:8] unchanged; next full legal scan -> frame_valid pulses only after all six are recommitted.
- dig_sel=000011 (multi-hot) held 10 cycles -> no err, no write; seg_in toggling every 2 cycles on digit 0 -> no commit.
- Blank 1111111 on digit 4 for 4 cycles -> bcd_out[19:16]=F, digit_valid[4]=1, no err.
- Assert rst for one cycle at cnt=3 mid-run -> all outputs 0 next cycle; unchanged inputs commit 4 samples after release.

Source files
------------

// File: rtl/seg7_scan_decoder.sv
// Receive-side 7-segment scan decoder: debounces a multiplexed active-low
// segment bus and recovers the BCD value of each digit position.
module seg7_scan_decoder #(
  parameter int DIGITS = 6,
  parameter int STABLE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [0:6]            seg_in,
  input  logic [DIGITS-1:0]     dig_sel,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     digit_valid,
  output logic                  frame_valid,
  output logic                  err,
  output logic [2:0]            err_digit
);

  localparam logic [3:0] STABLE_C = 4'(STABLE);

  // Returns {legal, value}; blank decodes legally to 4'hF.
  function automatic logic [4:0] decode(input logic [0:6] p);
    case (p)
      7'b0000001: decode = 5'h10;
      7'b1001111: decode = 5'h11;
      7'b0010010: decode = 5'h12;
      7'b0000110: decode = 5'h13;
      7'b1001100: decode = 5'h14;
      7'b0100100: decode = 5'h15;
      7'b0100000: decode = 5'h16;
      7'b0001101: decode = 5'h17;
      7'b0000000: decode = 5'h18;
      7'b0000100: decode = 5'h19;
      7'b1111111: decode = 5'h1F;
      default:    decode = 5'h00;
    endcase
  endfunction

  logic [0:6]        s_seg;
  logic [DIGITS-1:0] s_sel;
  logic [3:0]        cnt;
  logic [DIGITS-1:0] seen;

  logic              same;
  logic              commit;
  logic              onehot;
  logic [2:0]        idx;
  logic [4:0]        dec;
  logic [DIGITS-1:0] seen_next;

  always_comb begin
    same      = (s_sel == dig_sel) && (s_seg == seg_in);
    commit    = same && (cnt == (STABLE_C - 4'd1));
    onehot    = $onehot(s_sel);
    dec       = decode(s_seg);
    seen_next = seen | s_sel;
    idx       = 3'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (s_sel[i]) idx = 3'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_seg       <= 7'b1111111;
      s_sel       <= '0;
      cnt         <= 4'd0;
      seen        <= '0;
      bcd_out     <= '0;
      digit_valid <= '0;
      frame_valid <= 1'b0;
      err         <= 1'b0;
      err_digit   <= 3'd0;
    end else begin
      s_seg       <= seg_in;
      s_sel       <= dig_sel;
      frame_valid <= 1'b0;
      err         <= 1'b0;
      if (!same)                cnt <= 4'd1;
      else if (cnt != STABLE_C) cnt <= cnt + 4'd1;

      // Non-one-hot selects are blanking gaps or glitches and are dropped.
      if (commit && onehot) begin
        if (dec[4]) begin
          for (int i = 0; i < DIGITS; i++) begin
            if (s_sel[i]) begin
              bcd_out[4*i +: 4] <= dec[3:0];
              digit_valid[i]    <= 1'b1;
            end
          end
          if (seen_next == {DIGITS{1'b1}}) begin
            frame_valid <= 1'b1;
            seen        <= '0;
          end else begin
            seen <= seen_next;
          end
        end else begin
          err       <= 1'b1;
          err_digit <= idx;
          seen      <= '0;
          for (int i = 0; i < DIGITS; i++) begin
            if (s_sel[i]) digit_valid[i] <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed scans plus random bus traffic
// compared every cycle against a run-length reference model.
module tb_seg7_scan_decoder;
  localparam int DIGITS = 6;
  localparam int STABLE = 4;

  logic                clk;
  logic                rst;
  logic [0:6]          seg_in;
  logic [DIGITS-1:0]   dig_sel;
  logic [4*DIGITS-1:0] bcd_out;
  logic [DIGITS-1:0]   digit_valid;
  logic                frame_valid;
  logic                err;
  logic [2:0]          err_digit;

  seg7_scan_decoder #(.DIGITS(DIGITS), .STABLE(STABLE)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .dig_sel(dig_sel),
    .bcd_out(bcd_out), .digit_valid(digit_valid), .frame_valid(frame_valid),
    .err(err), .err_digit(err_digit)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int frames = 0;
  int errs   = 0;

  localparam logic [6:0] PAT [11] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
    7'b0100000, 7'b0001101, 7'b0000000, 7'b0000100, 7'b1111111
  };
  localparam logic [6:0] BLANK = 7'b1111111;

  function automatic int lookup(input logic [6:0] p);
    lookup = -1;
    for (int i = 0; i < 11; i++) if (PAT[i] == p) lookup = (i == 10) ? 15 : i;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: length of the current run of identical samples
  logic [DIGITS+6:0] m_prev;
  int                m_run;
  logic [3:0]        m_bcd [DIGITS];
  logic [DIGITS-1:0] m_valid, m_seen;
  logic              m_frame, m_err;
  logic [2:0]        m_errd;

  always @(posedge clk) begin
    logic [DIGITS+6:0]   cur;
    logic [DIGITS-1:0]   sel;
    logic [6:0]          pat;
    logic [4*DIGITS-1:0] flat;
    int                  pos, v;
    cur = {dig_sel, seg_in};
    sel = cur[DIGITS+6:7];
    pat = cur[6:0];
    m_frame = 1'b0;
    m_err   = 1'b0;
    if (rst) begin
      m_prev  = {{DIGITS{1'b0}}, BLANK};
      m_run   = 0;
      m_valid = '0;
      m_seen  = '0;
      m_errd  = 3'd0;
      for (int i = 0; i < DIGITS; i++) m_bcd[i] = 4'd0;
    end else begin
      m_run  = (cur == m_prev) ? m_run + 1 : 1;
      m_prev = cur;
      if (m_run == STABLE && $countones(sel) == 1) begin
        pos = 0;
        for (int i = 0; i < DIGITS; i++) if (sel[i]) pos = i;
        v = lookup(pat);
        if (v >= 0) begin
          m_bcd[pos]   = 4'(v);
          m_valid[pos] = 1'b1;
          m_seen[pos]  = 1'b1;
          if (&m_seen) begin
            m_frame = 1'b1;
            m_seen  = '0;
          end
        end else begin
          m_err        = 1'b1;
          m_errd       = 3'(pos);
          m_valid[pos] = 1'b0;
          m_seen       = '0;
        end
      end
    end
    #1;
    for (int i = 0; i < DIGITS; i++) flat[4*i +: 4] = m_bcd[i];
    chk("bcd_out", 32'(bcd_out), 32'(flat));
    chk("digit_valid", 32'(digit_valid), 32'(m_valid));
    chk("frame_valid", 32'(frame_valid), 32'(m_frame));
    chk("err", 32'(err), 32'(m_err));
    chk("err_digit", 32'(err_digit), 32'(m_errd));
    if (frame_valid) frames++;
    if (err) errs++;
  end

  // driver: apply a sample for n consecutive rising edges
  task automatic hold(input logic [DIGITS-1:0] sel, input logic [6:0] p, input int n);
    dig_sel = sel;
    seg_in  = p;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan(input int first, input int last);
    for (int d = first; d <= last; d++) begin
      hold(DIGITS'(1) << d, PAT[d+1], 6);
      hold('0, BLANK, 1);
    end
  endtask

  int f0, e0;
  logic [4*DIGITS-1:0] bcd_snap;

  initial begin
    rst = 1'b1;
    dig_sel = '0;
    seg_in = BLANK;
    repeat (2) @(negedge clk);
    chk("reset_bcd", 32'(bcd_out), 32'h0);
    chk("reset_valid", 32'(digit_valid), 32'h0);
    rst = 1'b0;

    hold(6'b000001, PAT[5], 3);
    hold('0, BLANK, 1);
    chk("short_hold_no_commit", 32'(digit_valid), 32'h0);
    hold(6'b000001, PAT[5], 4);
    chk("commit_d0_val", 32'(bcd_out[3:0]), 32'h5);
    chk("commit_d0_valid", 32'(digit_valid), 32'h01);
    hold('0, BLANK, 1);

    f0 = frames;
    scan(0, 5);
    chk("scan_bcd", 32'(bcd_out), 32'h654321);
    chk("scan_valid", 32'(digit_valid), 32'h3F);
    chk("scan_frames", 32'(frames - f0), 32'd1);

    e0 = errs;
    hold(6'b000100, 7'b1111110, 4);
    hold('0, BLANK, 1);
    chk("illegal_err", 32'(errs - e0), 32'd1);
    chk("illegal_err_digit", 32'(err_digit), 32'd2);
    chk("illegal_valid", 32'(digit_valid), 32'h3B);
    chk("illegal_bcd_kept", 32'(bcd_out[11:8]), 32'h3);
    f0 = frames;
    scan(0, 4);
    chk("partial_rescan_no_frame", 32'(frames - f0), 32'd0);
    scan(5, 5);
    chk("rescan_frame", 32'(frames - f0), 32'd1);

    e0 = errs;
    bcd_snap = bcd_out;
    hold(6'b000011, 7'b1111110, 10);
    for (int k = 0; k < 6; k++) hold(6'b000001, (k % 2) ? PAT[7] : PAT[8], 2);
    hold('0, BLANK, 1);
    chk("multihot_no_err", 32'(errs - e0), 32'd0);
    chk("multihot_toggle_no_write", 32'(bcd_out), 32'(bcd_snap));

    hold(6'b010000, BLANK, 4);
    chk("blank_val", 32'(bcd_out[19:16]), 32'hF);
    chk("blank_valid", 32'(digit_valid[4]), 32'h1);
    chk("blank_no_err", 32'(errs - e0), 32'd0);
    hold('0, BLANK, 1);

    hold(6'b000001, PAT[9], 3);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_bcd", 32'(bcd_out), 32'h0);
    chk("midrst_valid", 32'(digit_valid), 32'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("postrst_3_no_commit", 32'(digit_valid), 32'h0);
    @(negedge clk);
    chk("postrst_4_commit", 32'(bcd_out[3:0]), 32'h9);
    chk("postrst_4_valid", 32'(digit_valid), 32'h01);

    for (int n = 0; n < 400; n++) begin
      logic [DIGITS-1:0] sel;
      logic [6:0]        p;
      if ($urandom_range(0, 4) != 0) sel = DIGITS'(1) << $urandom_range(0, DIGITS-1);
      else sel = DIGITS'($urandom);
      if ($urandom_range(0, 5) != 0) p = PAT[$urandom_range(0, 10)];
      else p = 7'($urandom);
      hold(sel, p, $urandom_range(1, 7));
      if ($urandom_range(0, 60) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
